// File: rtl/tqvp_pwm_timer.sv
// PWM timer peripheral: register window with prescaler, shadowed PERIOD/DUTY,
// a wrap flag and a level interrupt.
module tqvp_pwm_timer #(
  parameter int CLOCK_MHZ = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam logic [5:0] ADDR_CTRL     = 6'h00;
  localparam logic [5:0] ADDR_PERIOD   = 6'h04;
  localparam logic [5:0] ADDR_DUTY     = 6'h08;
  localparam logic [5:0] ADDR_COUNT    = 6'h0C;
  localparam logic [5:0] ADDR_STATUS   = 6'h10;
  localparam logic [5:0] ADDR_PRESCALE = 6'h14;

  localparam logic [1:0] ACC_BYTE = 2'b00;
  localparam logic [1:0] ACC_HALF = 2'b01;
  localparam logic [1:0] ACC_WORD = 2'b10;
  localparam logic [1:0] ACC_NONE = 2'b11;

  // Byte writes touch only the low byte; wider writes replace the whole field.
  function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                          input logic [15:0] new_v,
                                          input logic [1:0]  acc);
    logic [15:0] mask;
    case (acc)
      ACC_BYTE: mask = 16'h00FF;
      ACC_HALF: mask = 16'hFFFF;
      ACC_WORD: mask = 16'hFFFF;
      default:  mask = 16'h0000;
    endcase
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] period_sh_q, period_sh_d;
  logic [15:0] duty_sh_q, duty_sh_d;
  logic [15:0] period_q, period_d;
  logic [15:0] duty_q, duty_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  prescale_q, prescale_d;
  logic        wrap_q, wrap_d;
  logic        pwm_q, pwm_d;
  logic        irq_q, irq_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;

  logic        wr_s;
  logic        rd_s;
  logic        en_s;
  logic        tick_s;
  logic        count_wr_s;
  logic        status_clr_s;
  logic        wrap_ev_s;
  logic        unused_s;

  assign unused_s = ^{ui_in, data_in[31:16], (CLOCK_MHZ > 0)};

  assign wr_s         = (data_write_n != ACC_NONE);
  assign rd_s         = (data_read_n != ACC_NONE);
  assign en_s         = ctrl_q[0];
  assign count_wr_s   = wr_s && (address == ADDR_COUNT);
  assign status_clr_s = wr_s && (address == ADDR_STATUS) && data_in[0];
  assign tick_s       = en_s && (presc_q == prescale_q);
  // A COUNT write pre-empts a coincident wrap.
  assign wrap_ev_s    = tick_s && (count_q == period_q) && !count_wr_s;

  // Timer, shadow and register-write next-state logic.
  always_comb begin
    if (!en_s || count_wr_s) begin
      count_d = 16'd0;
      presc_d = 8'd0;
    end else if (tick_s) begin
      presc_d = 8'd0;
      count_d = (count_q == period_q) ? 16'd0 : (count_q + 16'd1);
    end else begin
      presc_d = presc_q + 8'd1;
      count_d = count_q;
    end

    if (!en_s || wrap_ev_s) begin
      period_d = period_sh_q;
      duty_d   = duty_sh_q;
    end else begin
      period_d = period_q;
      duty_d   = duty_q;
    end

    if (wrap_ev_s) begin
      wrap_d = 1'b1;
    end else if (status_clr_s) begin
      wrap_d = 1'b0;
    end else begin
      wrap_d = wrap_q;
    end

    if (wr_s && (address == ADDR_CTRL)) begin
      ctrl_d = data_in[2:0];
    end else begin
      ctrl_d = ctrl_q;
    end

    if (wr_s && (address == ADDR_PERIOD)) begin
      period_sh_d = merge16(period_sh_q, data_in[15:0], data_write_n);
    end else begin
      period_sh_d = period_sh_q;
    end

    if (wr_s && (address == ADDR_DUTY)) begin
      duty_sh_d = merge16(duty_sh_q, data_in[15:0], data_write_n);
    end else begin
      duty_sh_d = duty_sh_q;
    end

    if (wr_s && (address == ADDR_PRESCALE)) begin
      prescale_d = data_in[7:0];
    end else begin
      prescale_d = prescale_q;
    end

    // Outputs are computed from next state so they line up with the counter.
    pwm_d = (ctrl_d[0] && (count_d < duty_d)) ^ ctrl_d[2];
    irq_d = wrap_d && ctrl_d[1];
  end

  // Read data mux, registered one cycle after the request.
  always_comb begin
    rdata_d = 32'd0;
    if (rd_s) begin
      case (address)
        ADDR_CTRL:     rdata_d = {29'd0, ctrl_q};
        ADDR_PERIOD:   rdata_d = {16'd0, period_sh_q};
        ADDR_DUTY:     rdata_d = {16'd0, duty_sh_q};
        ADDR_COUNT:    rdata_d = {16'd0, count_q};
        ADDR_STATUS:   rdata_d = {31'd0, wrap_q};
        ADDR_PRESCALE: rdata_d = {24'd0, prescale_q};
        default:       rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end
    ready_d = rd_s;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q      <= 3'd0;
      period_sh_q <= 16'd0;
      duty_sh_q   <= 16'd0;
      period_q    <= 16'd0;
      duty_q      <= 16'd0;
      count_q     <= 16'd0;
      presc_q     <= 8'd0;
      prescale_q  <= 8'd0;
      wrap_q      <= 1'b0;
      pwm_q       <= 1'b0;
      irq_q       <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      ctrl_q      <= ctrl_d;
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      prescale_q  <= prescale_d;
      wrap_q      <= wrap_d;
      pwm_q       <= pwm_d;
      irq_q       <= irq_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
    end
  end

  assign uo_out         = {6'b000000, ~pwm_q, pwm_q};
  assign data_out       = rdata_q;
  assign data_ready     = ready_q;
  assign user_interrupt = irq_q;

endmodule

// File: tb/tb_tqvp_pwm_timer.sv
// Randomized + directed bench for tqvp_pwm_timer with a behavioural model and
// a read-data scoreboard drained by an independent monitor.
module tb_tqvp_pwm_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  always #5 clk = ~clk;

  tqvp_pwm_timer #(.CLOCK_MHZ(64)) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [7:0]  mon_uo;

  // Model state, plain integers.
  int m_ctrl, m_per_sh, m_duty_sh, m_per, m_duty, m_cnt, m_pre, m_prescale, m_wrap;
  bit m_pwm, m_irq, m_ready;

  function automatic int wr16(input int old, input logic [31:0] d, input logic [1:0] wn);
    if (wn == 2'b00) return (old / 256) * 256 + int'(d % 32'd256);
    return int'(d % 32'd65536);
  endfunction

  // One clock edge of the peripheral as seen from its register map.
  task automatic model_step(input logic [5:0] a, input logic [31:0] d,
                            input logic [1:0] wn, input logic [1:0] rn, input bit r);
    int rv;
    bit en, wr, wev;
    if (r) begin
      m_ctrl = 0; m_per_sh = 0; m_duty_sh = 0; m_per = 0; m_duty = 0;
      m_cnt = 0; m_pre = 0; m_prescale = 0; m_wrap = 0;
      m_pwm = 1'b0; m_irq = 1'b0; m_ready = 1'b0;
      return;
    end
    if (rn != 2'b11) begin
      case (a)
        6'h00:   rv = m_ctrl;
        6'h04:   rv = m_per_sh;
        6'h08:   rv = m_duty_sh;
        6'h0C:   rv = m_cnt;
        6'h10:   rv = m_wrap;
        6'h14:   rv = m_prescale;
        default: rv = 0;
      endcase
      exp_q.push_back(32'(rv));
    end
    m_ready = (rn != 2'b11);
    wr  = (wn != 2'b11);
    en  = (m_ctrl % 2) == 1;
    wev = 1'b0;
    if (!en) begin
      m_cnt = 0; m_pre = 0;
    end else if (m_pre == m_prescale) begin
      m_pre = 0;
      if (m_cnt == m_per) begin m_cnt = 0; wev = 1'b1; end
      else m_cnt++;
    end else begin
      m_pre++;
    end
    if (wr && a == 6'h0C) begin m_cnt = 0; m_pre = 0; wev = 1'b0; end
    if (!en || wev) begin m_per = m_per_sh; m_duty = m_duty_sh; end
    if (wr && a == 6'h10 && (d % 32'd2) == 32'd1) m_wrap = 0;
    if (wev) m_wrap = 1;
    if (wr) begin
      case (a)
        6'h00:   m_ctrl = int'(d % 32'd8);
        6'h04:   m_per_sh = wr16(m_per_sh, d, wn);
        6'h08:   m_duty_sh = wr16(m_duty_sh, d, wn);
        6'h14:   m_prescale = int'(d % 32'd256);
        default: ;
      endcase
    end
    m_pwm = (((m_ctrl % 2) == 1) && (m_cnt < m_duty)) ^ (((m_ctrl / 4) % 2) == 1);
    m_irq = (m_wrap == 1) && (((m_ctrl / 2) % 2) == 1);
  endtask

  task automatic cyc(input logic [5:0] a, input logic [31:0] d,
                     input logic [1:0] wn, input logic [1:0] rn, input bit r);
    address = a; data_in = d; data_write_n = wn; data_read_n = rn; rst = r;
    ui_in = 8'($urandom_range(0, 255));
    @(posedge clk);
    model_step(a, d, wn, rn, r);
    #1;
  endtask

  task automatic wrw(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    cyc(a, d, wn, 2'b11, 1'b0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    cyc(a, d, 2'b10, 2'b11, 1'b0);
  endtask

  task automatic rd(input logic [5:0] a);
    cyc(a, $urandom(), 2'b11, 2'($urandom_range(0, 2)), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(6'h3F, 32'd0, 2'b11, 2'b11, 1'b0);
  endtask

  task automatic read_all();
    logic [5:0] addrs [8];
    addrs = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h3F};
    for (int i = 0; i < 8; i++) rd(addrs[i]);
  endtask

  task automatic wait_cnt(input int target);
    for (int i = 0; i < 200; i++) begin
      if (m_cnt == target) break;
      idle(1);
    end
    vectors++;
    if (m_cnt != target) begin
      miscompares++;
      $display("FAIL wait_count: count %0d, wanted %0d within bound", m_cnt, target);
    end
  endtask

  task automatic rand_cycle();
    logic [5:0]  a;
    logic [31:0] d;
    logic [1:0]  wn, rn;
    bit          r;
    case ($urandom_range(0, 7))
      0: a = 6'h00;
      1: a = 6'h04;
      2: a = 6'h08;
      3: a = 6'h0C;
      4: a = 6'h10;
      5: a = 6'h14;
      default: a = 6'($urandom_range(0, 63));
    endcase
    d = $urandom();
    if ($urandom_range(0, 3) != 0) begin
      d[15:0] = 16'($urandom_range(0, 20));
      if (a == 6'h14) d[7:0] = 8'($urandom_range(0, 3));
    end
    if (a == 6'h00 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
    wn = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
    rn = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
    r  = ($urandom_range(0, 299) == 0);
    cyc(a, d, wn, rn, r);
  endtask

  // Monitor: per-cycle output checks and scoreboard drain on data_ready.
  always @(negedge clk) begin
    if (checking) begin
      mon_uo = m_pwm ? 8'h01 : 8'h02;
      vectors++;
      if (uo_out !== mon_uo) begin
        miscompares++;
        $display("FAIL uo_out: got %h, expected %h at %0t", uo_out, mon_uo, $time);
      end
      vectors++;
      if (user_interrupt !== m_irq) begin
        miscompares++;
        $display("FAIL user_interrupt: got %b, expected %b at %0t", user_interrupt, m_irq, $time);
      end
      vectors++;
      if (data_ready !== m_ready) begin
        miscompares++;
        $display("FAIL data_ready: got %b, expected %b at %0t", data_ready, m_ready, $time);
      end
      if (data_ready === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL read_data: got %h, expected no response at %0t", data_out, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          if (data_out !== mon_exp) begin
            miscompares++;
            $display("FAIL read_data: got %h, expected %h at %0t", data_out, mon_exp, $time);
          end
        end
      end
    end
  end

  initial begin
    cyc(6'h00, 32'd0, 2'b11, 2'b11, 1'b1);
    checking = 1'b1;
    cyc(6'h00, 32'd0, 2'b11, 2'b11, 1'b1);
    read_all();

    // Basic PWM: PERIOD=9, DUTY=3
    wr(6'h04, 32'd9); wr(6'h08, 32'd3); wr(6'h14, 32'd0); wr(6'h00, 32'd1);
    idle(25); rd(6'h10);

    // Shadow update mid-period
    wait_cnt(6); wr(6'h08, 32'd5); idle(30);

    // Prescaler and interrupt
    wr(6'h00, 32'd0); wr(6'h14, 32'd3); wr(6'h04, 32'd1); wr(6'h10, 32'd1);
    wr(6'h00, 32'd3); idle(12); wr(6'h10, 32'd1); idle(3); rd(6'h10);

    // Bounds
    wr(6'h00, 32'd0); wr(6'h14, 32'd0); wr(6'h08, 32'd0); wr(6'h04, 32'd9);
    wr(6'h00, 32'd1); idle(15); wr(6'h08, 32'd20); idle(25);
    wr(6'h00, 32'd0); wr(6'h08, 32'd0); wr(6'h00, 32'd5); idle(15);

    // Access widths
    wr(6'h00, 32'd0);
    wrw(6'h04, 32'h0000ABCD, 2'b00); rd(6'h04);
    wrw(6'h08, 32'h12345678, 2'b01); rd(6'h08);
    wrw(6'h14, 32'hFFFFFF05, 2'b10); rd(6'h14);
    wrw(6'h00, 32'hFFFFFFF8, 2'b00); rd(6'h00);

    // STATUS clear colliding with a wrap (PERIOD=0 wraps every tick)
    wr(6'h14, 32'd0); wr(6'h04, 32'd0); wr(6'h00, 32'd1); idle(3);
    wr(6'h10, 32'd1); rd(6'h10);

    // COUNT write colliding with a wrapping tick
    wr(6'h00, 32'd0); wr(6'h04, 32'd3); wr(6'h10, 32'd1); wr(6'h00, 32'd1);
    wait_cnt(3); wr(6'h0C, 32'hFFFF); rd(6'h10); rd(6'h0C);
    idle(5); rd(6'h0C); rd(6'h0C);

    // Reset while running
    wr(6'h00, 32'd7); idle(4);
    cyc(6'h0C, 32'd0, 2'b11, 2'b10, 1'b1);
    read_all();

    for (int i = 0; i < 3000; i++) rand_cycle();
    idle(3);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL read_queue: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tqvp_pwm_timer.md
TQVP_PWM_TIMER -- requirements
Module: tqvp_pwm_timer

Interface
REQ-001 SHALL have parameter CLOCK_MHZ, default 64, system clock frequency in MHz; informational only, no function depends on it.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port ui_in, input, 8, input PMOD; unused, no function depends on it.
REQ-005 SHALL have port uo_out, output, 8, with [0]=pwm, [1]=~pwm, [7:2]=0.
REQ-006 SHALL have port address, input, 6, byte address within the 64-byte user peripheral window.
REQ-007 SHALL have port data_in, input, 32, write data; bits [7:0], [15:0] or [31:0] are valid per width.
REQ-008 SHALL have port data_write_n, input, 2, write request: 11 none, 00 byte, 01 halfword, 10 word.
REQ-009 SHALL have port data_read_n, input, 2, read request, same encoding as data_write_n.
REQ-010 SHALL have port data_out, output, 32, registered read data.
REQ-011 SHALL have port data_ready, output, 1, read data valid.
REQ-012 SHALL have port user_interrupt, output, 1, level interrupt.

Function
REQ-013 SHALL decode registers: 0x00 CTRL, 0x04 PERIOD, 0x08 DUTY, 0x0C COUNT, 0x10 STATUS, 0x14 PRESCALE.
- CTRL: [0] EN, [1] IRQ_EN, [2] INV.
- PERIOD: 16-bit.
- DUTY: 16-bit.
- COUNT: 16-bit; reads the counter; any write clears the counter and the prescaler.
- STATUS: [0] WRAP; writing 1 clears it.
- PRESCALE: 8-bit.
Other addresses read 0 and ignore writes.
REQ-014 SHALL apply byte writes to bits [7:0] only, halfword writes to [15:0] only, and word writes to all implemented bits; bits above a register's width are ignored.
REQ-015 SHALL return reads zero-extended to 32 bits.
REQ-016 SHALL register read data, with data_out and data_ready valid the cycle after data_read_n != 11, and data_ready low otherwise.
REQ-017 SHALL accept writes in the cycle data_write_n != 11, with the effect visible from the next cycle.
REQ-018 SHALL hold PERIOD and DUTY writes in shadow registers.
- Shadows copy to the active registers at each counter wrap.
- While EN=0, shadows copy to the active registers every cycle.
REQ-019 SHALL, while EN=1, count the prescaler 0..PRESCALE.
- When prescaler==PRESCALE, assert a 1-cycle tick and return the prescaler to 0.
- PRESCALE=0 gives a tick every cycle.
REQ-020 SHALL update the counter on each tick.
- If counter==active PERIOD: counter<=0 and WRAP<=1 (wrap event).
- Otherwise: counter<=counter+1.
REQ-021 SHALL reset the counter and prescaler to 0 and hold them while EN=0.
REQ-022 SHALL drive raw pwm = EN && (counter < active DUTY), registered, and pwm = raw pwm XOR INV.
- DUTY=0: pwm is constant low (INV=0).
- DUTY>PERIOD: pwm is constant high (INV=0).
- PERIOD=0: every tick is a wrap event.
REQ-023 SHALL let the set win when a STATUS clear write and a wrap event occur in the same cycle.
REQ-024 SHALL let the COUNT write win when a COUNT write coincides with a tick: counter=0 and no wrap event.
REQ-025 SHALL drive user_interrupt = WRAP && IRQ_EN, registered, and hold it until WRAP is cleared.
REQ-026 SHALL leave data_write_n == 00/01/10 writes with no data_ready dependency; the wrapper acknowledges writes.

Reset
REQ-027 SHALL, while rst=1, clear these to 0 on the clock edge: CTRL, PERIOD/DUTY shadow and active registers, COUNT, prescaler, STATUS, PRESCALE, data_out, data_ready, pwm register, user_interrupt.
REQ-028 SHALL, after reset, output uo_out=8'b0000_0010 (pwm=0, [1]=1).
REQ-029 SHALL, when reset is asserted mid-period, return to the REQ-027 state in one cycle with no wrap event.

Verification
REQ-030 Basic PWM: PERIOD=9, DUTY=3, PRESCALE=0, CTRL=1 -> uo_out[0] high 3 cycles and low 7, repeating every 10 cycles; WRAP sets at the first wrap.
REQ-031 Prescaler and interrupt: PRESCALE=3, PERIOD=1, CTRL=3 -> first wrap at 8 cycles after enable, user_interrupt=1; write STATUS=1 -> user_interrupt=0 the cycle after.
REQ-032 Shadow update: running PERIOD=9, DUTY=3; write DUTY=5 when COUNT==6 -> pulses stay 3 wide until the wrap, then become 5 wide.
REQ-033 Bounds: DUTY=0 -> pwm stays 0; DUTY=20 with PERIOD=9 -> pwm stays 1; CTRL=5 (INV=1) with DUTY=0 -> pwm stays 1.
REQ-034 Widths and collisions: byte write 0xABCD to PERIOD -> reads 0x000000CD; STATUS clear in the same cycle as a wrap -> WRAP reads 1.
REQ-035 Read latency and reset: read COUNT -> data_ready high exactly the next cycle with the value; rst pulse while running -> all registers read 0 and uo_out=0x02.
